// File: rtl/cipher_rounds.sv
// -----------------------------------------------------------------------------
// cipher_rounds -- iterative AES encryption datapath. One round runs per
// consumed round key. The key schedule lives upstream: this block takes one
// round key per cycle and holds the key stage with keyHold whenever it is not
// consuming a key.
//
// Ports
//   clk         system clock, rising edge
//   reset       asynchronous, active-high; forces IDLE with a cleared state
//   start       load plaintext and begin (accepted in IDLE or DONE only)
//   plaintext   128-bit input block, FIPS-197 byte order (byte0 = [127:120])
//   roundKey    round key for the round the block is currently on
//   rkValid     roundKey is valid this cycle; low stalls the round in flight
//   keyHold     freezes the upstream key expansion (drives its done2 input)
//   busy        high while in RUN
//   done        high while in DONE; ciphertext is valid
//   ciphertext  the state register, same byte order as plaintext
//
// Parameter
//   NR          number of AES rounds: 10, 12 or 14
// -----------------------------------------------------------------------------

// 32-bit SubWord: the AES S-box applied to each of four bytes.
module subword (
  input  logic [31:0] word,
  output logic [31:0] sub
);

  // NOTE: the S-box is a constant ROM table; it holds no state and needs no reset.
  localparam logic [0:255][7:0] SBOX = {
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  assign sub[31:24] = SBOX[word[31:24]];
  assign sub[23:16] = SBOX[word[23:16]];
  assign sub[15:8]  = SBOX[word[15:8]];
  assign sub[7:0]   = SBOX[word[7:0]];

endmodule

module cipher_rounds #(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [127:0] plaintext,
  input  logic [127:0] roundKey,
  input  logic         rkValid,
  output logic         keyHold,
  output logic         busy,
  output logic         done,
  output logic [127:0] ciphertext
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0] NR_L = 4'(NR);

  state_t       state;
  logic [3:0]   rnd;
  logic [127:0] st;

  logic [127:0] sb;     // SubBytes(st)
  logic [127:0] sr;     // ShiftRows(SubBytes(st)) -- final round
  logic [127:0] mc;     // MixColumns(ShiftRows(SubBytes(st))) -- middle rounds

  // Byte (row r, column c) sits at bits [127-8*(4c+r) -: 8] (column-major).
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
      end
    end
    return o;
  endfunction

  // Multiply by x in GF(2^8), reduction polynomial 0x11b.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] mix_column(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = col;
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    return {mix_column(s[127:96]), mix_column(s[95:64]),
            mix_column(s[63:32]),  mix_column(s[31:0])};
  endfunction

  // Four SubWord instances cover the 16 state bytes.
  for (genvar g = 0; g < 4; g++) begin : g_sbox
    subword u_subword (
      .word (st[32*g +: 32]),
      .sub  (sb[32*g +: 32])
    );
  end

  assign sr = shift_rows(sb);
  assign mc = mix_columns(sr);

  assign ciphertext = st;

  // keyHold must react to rkValid in the same cycle so the key stage freezes
  // on exactly the cycle the round stalls; it cannot be a registered output.
  assign keyHold = (state != RUN) || !rkValid;

  // NOTE: every register here is assigned with <= so all flops sample the
  // pre-edge values of st/rnd/state, whatever order the statements appear in.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      rnd   <= 4'd0;
      st    <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            st    <= plaintext;
            rnd   <= 4'd0;
            state <= RUN;
            busy  <= 1'b1;
            done  <= 1'b0;
          end
        end

        RUN: begin
          if (rnd > NR_L) begin
            // Counter corrupted: abandon the block rather than emit garbage.
            state <= IDLE;
            rnd   <= 4'd0;
            busy  <= 1'b0;
            done  <= 1'b0;
          end else if (rkValid) begin
            if (rnd == 4'd0) begin
              st  <= st ^ roundKey;
              rnd <= 4'd1;
            end else if (rnd < NR_L) begin
              st  <= mc ^ roundKey;
              rnd <= rnd + 4'd1;
            end else begin
              // Last round omits MixColumns.
              st    <= sr ^ roundKey;
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
        end

        default: begin
          state <= IDLE;
          rnd   <= 4'd0;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cipher_rounds.sv
// -----------------------------------------------------------------------------
// tb_cipher_rounds -- directed bench for cipher_rounds with NR=10 and NR=14.
// Round keys come from a small key-expansion model here in the bench; expected
// ciphertexts are the published FIPS-197 vectors.
//
// Timing reference: edge t is the rising edge just before start is raised, so
// the load happens at t+1 and, without stalls, done is first seen after
// t+NR+2 (NR+1 key consumptions at t+2 .. t+NR+2).
// -----------------------------------------------------------------------------
module tb_cipher_rounds;

  logic         clk;
  logic         reset;
  logic         start_drv;
  logic         sel14;
  logic [127:0] plaintext;
  logic [127:0] roundKey;
  logic         rkValid;

  logic         start10, keyHold10, busy10, done10;
  logic         start14, keyHold14, busy14, done14;
  logic [127:0] ct10, ct14;

  logic         cur_kh, cur_busy, cur_done;
  logic [127:0] cur_ct;

  int n_checks = 0;
  int n_fail   = 0;

  logic [127:0] keys [0:14];

  localparam logic [0:255][7:0] SBOX = {
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  localparam logic [127:0] PT_C1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT_C3 = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [255:0] KEY_C1 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
  localparam logic [255:0] KEY_C3 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [255:0] KEY_B = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};

  assign start10 = start_drv & ~sel14;
  assign start14 = start_drv &  sel14;

  assign cur_kh   = sel14 ? keyHold14 : keyHold10;
  assign cur_busy = sel14 ? busy14    : busy10;
  assign cur_done = sel14 ? done14    : done10;
  assign cur_ct   = sel14 ? ct14      : ct10;

  cipher_rounds #(.NR(10)) dut10 (
    .clk        (clk),
    .reset      (reset),
    .start      (start10),
    .plaintext  (plaintext),
    .roundKey   (roundKey),
    .rkValid    (rkValid),
    .keyHold    (keyHold10),
    .busy       (busy10),
    .done       (done10),
    .ciphertext (ct10)
  );

  cipher_rounds #(.NR(14)) dut14 (
    .clk        (clk),
    .reset      (reset),
    .start      (start14),
    .plaintext  (plaintext),
    .roundKey   (roundKey),
    .rkValid    (rkValid),
    .keyHold    (keyHold14),
    .busy       (busy14),
    .done       (done14),
    .ciphertext (ct14)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
  endfunction

  // FIPS-197 key expansion; key is left-aligned, nk = 4 (AES-128) or 8 (AES-256).
  task automatic expand(input logic [255:0] key, input int nk);
    logic [31:0] w [0:59];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
    for (int i = nk; i < 4*(nk+7); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = xt(rc);
      end else if (nk > 6 && i % nk == 4) begin
        t = subw(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int r = 0; r <= nk+6; r++) keys[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // Runs one encryption starting from a negedge. Optional events: a stall of
  // stall_len cycles at round stall_rnd, a start pulse at glitch_rnd, or a
  // reset pulse at reset_rnd (aborts the run). Pass -1 to disable an event.
  task automatic encrypt(input int nr, input logic [127:0] pt, input logic [127:0] exp_ct,
                         input int stall_rnd, input int stall_len, input int glitch_rnd,
                         input int reset_rnd, input string name);
    int k, stalls, edges;
    bit aborted;
    k = 0; stalls = 0; edges = 0; aborted = 0;
    sel14     = (nr == 14);
    plaintext = pt;
    start_drv = 1'b1;
    rkValid   = 1'b0;
    @(posedge clk);            // t+1: load
    edges = 1;
    @(negedge clk);
    start_drv = 1'b0;
    while (k <= nr && edges < 200) begin
      if (k == reset_rnd) begin
        reset = 1'b1;
        #1;
        n_checks++;
        if (cur_done !== 1'b0 || cur_ct !== 128'h0 || cur_busy !== 1'b0 || cur_kh !== 1'b1) begin
          n_fail++;
          $display("FAIL %s async reset: done=%b busy=%b keyHold=%b ct=%h, required 0 0 1 0",
                   name, cur_done, cur_busy, cur_kh, cur_ct);
        end
        aborted = 1;
        break;
      end
      n_checks++;
      if (cur_busy !== 1'b1 || cur_done !== 1'b0) begin
        n_fail++;
        $display("FAIL %s run flags k=%0d: busy=%b done=%b, required 1 0", name, k, cur_busy, cur_done);
      end
      roundKey  = keys[k];
      rkValid   = !(k == stall_rnd && stalls < stall_len);
      start_drv = (k == glitch_rnd);
      #1;
      n_checks++;
      if (cur_kh !== !rkValid) begin
        n_fail++;
        $display("FAIL %s keyHold k=%0d: got %b, required %b", name, k, cur_kh, !rkValid);
      end
      @(posedge clk);
      edges++;
      if (rkValid) k++;
      else stalls++;
      @(negedge clk);
    end
    rkValid   = 1'b0;
    start_drv = 1'b0;
    if (aborted) begin
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      n_checks++;
      if (cur_busy !== 1'b0 || cur_done !== 1'b0 || cur_ct !== 128'h0 || cur_kh !== 1'b1) begin
        n_fail++;
        $display("FAIL %s post-reset idle: busy=%b done=%b keyHold=%b ct=%h", name, cur_busy, cur_done, cur_kh, cur_ct);
      end
    end else begin
      n_checks++;
      if (cur_done !== 1'b1 || cur_busy !== 1'b0 || edges != nr + 2 + stalls) begin
        n_fail++;
        $display("FAIL %s latency: done=%b busy=%b at t+%0d, required done=1 busy=0 at t+%0d",
                 name, cur_done, cur_busy, edges, nr + 2 + stalls);
      end
      n_checks++;
      if (cur_ct !== exp_ct) begin
        n_fail++;
        $display("FAIL %s ciphertext: got %h, required %h", name, cur_ct, exp_ct);
      end
      n_checks++;
      if (cur_kh !== 1'b1) begin
        n_fail++;
        $display("FAIL %s keyHold in DONE: got %b, required 1", name, cur_kh);
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_checks++;
    if (busy10 !== 1'b0 || done10 !== 1'b0 || keyHold10 !== 1'b1 || ct10 !== 128'h0) begin
      n_fail++;
      $display("FAIL reset nr10: busy=%b done=%b keyHold=%b ct=%h, required 0 0 1 0", busy10, done10, keyHold10, ct10);
    end
    n_checks++;
    if (busy14 !== 1'b0 || done14 !== 1'b0 || keyHold14 !== 1'b1 || ct14 !== 128'h0) begin
      n_fail++;
      $display("FAIL reset nr14: busy=%b done=%b keyHold=%b ct=%h, required 0 0 1 0", busy14, done14, keyHold14, ct14);
    end
    reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (busy10 !== 1'b0 || done10 !== 1'b0 || keyHold10 !== 1'b1) begin
      n_fail++;
      $display("FAIL idle hold: busy=%b done=%b keyHold=%b, required 0 0 1", busy10, done10, keyHold10);
    end
  endtask

  task automatic test_c1();
    expand(KEY_C1, 4);
    encrypt(10, PT_C1, CT_C1, -1, 0, -1, -1, "c1");
    // DONE must hold its result while start stays low.
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (done10 !== 1'b1 || ct10 !== CT_C1) begin
      n_fail++;
      $display("FAIL c1 done hold: done=%b ct=%h, required 1 %h", done10, ct10, CT_C1);
    end
  endtask

  task automatic test_stall();
    expand(KEY_C1, 4);
    encrypt(10, PT_C1, CT_C1, 5, 3, -1, -1, "stall");
  endtask

  task automatic test_start_ignored();
    expand(KEY_C1, 4);
    encrypt(10, PT_C1, CT_C1, -1, 0, 4, -1, "start_in_run");
  endtask

  task automatic test_reset_mid_run();
    expand(KEY_C1, 4);
    encrypt(10, PT_C1, CT_C1, -1, 0, -1, 7, "reset_mid");
    encrypt(10, PT_C1, CT_C1, -1, 0, -1, -1, "after_reset");
  endtask

  task automatic test_back_to_back();
    expand(KEY_C1, 4);
    encrypt(10, PT_C1, CT_C1, -1, 0, -1, -1, "b2b_first");
    expand(KEY_B, 4);
    encrypt(10, PT_B, CT_B, -1, 0, -1, -1, "b2b_second");
  endtask

  task automatic test_nr14();
    expand(KEY_C3, 8);
    encrypt(14, PT_C1, CT_C3, -1, 0, -1, -1, "c3_nr14");
    sel14 = 1'b0;
  endtask

  initial begin
    reset     = 1'b1;
    start_drv = 1'b0;
    sel14     = 1'b0;
    plaintext = '0;
    roundKey  = '0;
    rkValid   = 1'b0;

    test_reset();
    test_c1();
    @(negedge clk);
    test_stall();
    @(negedge clk);
    test_start_ignored();
    @(negedge clk);
    test_reset_mid_run();
    @(negedge clk);
    test_back_to_back();
    @(negedge clk);
    test_nr14();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
